// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
// Holds the frame-level state encoding and the line/frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Clocks per oversample tick; integer division, so the baud error is the caller's concern.
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clk domain.
// Both flops reset to the idle line level so reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      sync_reg <= {2{IDLE_LEVEL}};
    end else begin
      sync_reg <= {sync_reg[0], d};
    end
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits, LSB first, one stop bit.
// Start bit is re-checked at mid-bit; a low stop bit flags frame_err and waits for line idle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 2400,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       frame_err
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk  (clk),
    .srst (srst),
    .d    (rx),
    .q    (rx_s)
  );

  // Free-running sample-tick divider
  logic [DIV_W-1:0] div_reg;
  logic             tick;

  assign tick = (div_reg == DIV_LAST);

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  uart_state_t            state_reg, state_next;
  logic [TICK_W-1:0]      tick_cnt_reg, tick_cnt_next;
  logic [BIT_W-1:0]       bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   valid_reg, valid_next;
  logic                   ferr_reg, ferr_next;
  // Set after a bad stop bit: remain in STOP until the line returns to idle
  logic                   brk_reg, brk_next;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      ferr_reg     <= 1'b0;
      brk_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      ferr_reg     <= ferr_next;
      brk_reg      <= brk_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    ferr_next     = 1'b0;
    brk_next      = brk_reg;

    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (rx_s != IDLE_LEVEL) begin
            state_next    = START;
            tick_cnt_next = '0;
          end
        end

        START: begin
          if (tick_cnt_reg == MID_TICK) begin
            if (rx_s != IDLE_LEVEL) begin
              state_next    = DATA;
              tick_cnt_next = '0;
              bit_idx_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TICK_W'(1);
          end
        end

        DATA: begin
          if (tick_cnt_reg == LAST_TICK) begin
            shift_next    = {rx_s, shift_reg[DATA_BITS-1:1]};
            tick_cnt_next = '0;
            if (bit_idx_reg == LAST_BIT) begin
              state_next = STOP;
              brk_next   = 1'b0;
            end else begin
              bit_idx_next = bit_idx_reg + BIT_W'(1);
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TICK_W'(1);
          end
        end

        STOP: begin
          if (brk_reg) begin
            if (rx_s == IDLE_LEVEL) begin
              state_next = IDLE;
              brk_next   = 1'b0;
            end
          end else if (tick_cnt_reg == LAST_TICK) begin
            if (rx_s == IDLE_LEVEL) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_next = 1'b1;
              brk_next  = 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + TICK_W'(1);
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_reg;
  assign valid     = valid_reg;
  assign frame_err = ferr_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural line driver acts as the transmitter,
// and a byte-level model predicts which bytes must appear on data_out and in what order.
module tb_uart_rx;

  localparam int CLK_FREQ = 384000;
  localparam int BAUD     = 2400;
  localparam int OS       = 16;
  localparam int BIT_CLK  = CLK_FREQ / BAUD;

  logic       clk  = 1'b0;
  logic       srst = 1'b1;
  logic       rx   = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk       (clk),
    .srst      (srst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bytes that must be delivered, and the byte data_out must hold
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;

  // Observed behaviour
  logic [7:0] got_q[$];
  int valid_cnt = 0, ferr_cnt = 0, both_cnt = 0, long_cnt = 0, unstable_cnt = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(data_out);
      valid_cnt++;
    end
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) both_cnt++;
    if (valid && prev_valid) long_cnt++;
    if (!srst && !valid && data_out !== prev_data) unstable_cnt++;
    prev_valid = valid;
    prev_data  = data_out;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) begin
      exp_q.push_back(b);
      exp_data = b;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_clk);
    logic [8:0] f;
    f = {b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx = f[i];
      repeat (BIT_CLK) @(posedge clk);
    end
    rx = stop_lvl;
    repeat (stop_clk) @(posedge clk);
  endtask

  task automatic test_reset();
    srst = 1'b1;
    rx   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
    n_tests++; if ({valid, busy, frame_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {valid, busy, frame_err}); end
    @(negedge clk);
    srst = 1'b0;
    repeat (40) @(posedge clk);
  endtask

  task automatic test_single_frame();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, BIT_CLK);
    model_frame(8'hA5, 1'b1);
    #1;
    n_tests++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL a5_valid_count: got %0d expected 1", valid_cnt - v0); end
    n_tests++; if (data_out !== exp_data) begin n_fail++; $display("FAIL a5_data: got %h expected %h", data_out, exp_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy: got %b expected 0", busy); end
    n_tests++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL a5_frame_err: got %0d expected 0", ferr_cnt - f0); end
    repeat (BIT_CLK) @(posedge clk);
  endtask

  task automatic test_glitch();
    int v0, f0, waited;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (40) @(posedge clk);
    rx = 1'b1;
    waited = 0;
    while (busy && waited < 120) begin
      @(posedge clk);
      waited++;
    end
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0 within 120 clk", busy); end
    repeat (2 * BIT_CLK) @(posedge clk);
    n_tests++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d pulses expected 0", valid_cnt - v0); end
    n_tests++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", ferr_cnt - f0); end
  endtask

  task automatic test_frame_error();
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 2 * BIT_CLK);
    model_frame(8'h3C, 1'b0);
    #1;
    n_tests++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
    n_tests++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected 0", valid_cnt - v0); end
    n_tests++; if (data_out !== exp_data) begin n_fail++; $display("FAIL ferr_data_kept: got %h expected %h", data_out, exp_data); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %b expected 1", busy); end
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b expected 0", busy); end
    n_tests++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_no_restart: got %0d expected 1", ferr_cnt - f0); end
    repeat (BIT_CLK) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int base;
    base = got_q.size();
    send_frame(8'h00, 1'b1, BIT_CLK);
    model_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1, BIT_CLK);
    model_frame(8'hFF, 1'b1);
    #1;
    n_tests++; if (got_q.size() - base !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", got_q.size() - base); end
    if (got_q.size() - base == 2) begin
      n_tests++; if (got_q[base] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got %h expected 00", got_q[base]); end
      n_tests++; if (got_q[base+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got %h expected ff", got_q[base+1]); end
    end
    n_tests++; if (data_out !== exp_data) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", data_out, exp_data); end
    repeat (BIT_CLK) @(posedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    logic [8:0] f;
    f = {8'h81, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = f[i];
      repeat (BIT_CLK) @(posedge clk);
    end
    rx = 1'b0;
    repeat (BIT_CLK / 2) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
    #2;
    srst = 1'b1;
    #1;
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 00", data_out); end
    n_tests++; if ({valid, busy, frame_err} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 000", {valid, busy, frame_err}); end
    exp_data = 8'h00;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
    v0 = valid_cnt; f0 = ferr_cnt;
    repeat (3 * BIT_CLK) @(posedge clk);
    #1;
    n_tests++; if (valid_cnt - v0 !== 0 || ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL rst_mid_no_pulse: got valid %0d ferr %0d expected 0 0", valid_cnt - v0, ferr_cnt - f0); end
    send_frame(8'h55, 1'b1, BIT_CLK);
    model_frame(8'h55, 1'b1);
    #1;
    n_tests++; if (data_out !== exp_data) begin n_fail++; $display("FAIL rst_mid_next: got %h expected %h", data_out, exp_data); end
    n_tests++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rst_mid_next_valid: got %0d expected 1", valid_cnt - v0); end
    repeat (BIT_CLK) @(posedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0] sent[$];
    logic [7:0] b;
    int base;
    base = got_q.size();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      send_frame(b, 1'b1, BIT_CLK);
      model_frame(b, 1'b1);
      repeat ($urandom_range(0, 3) * 40) @(posedge clk);
    end
    repeat (BIT_CLK) @(posedge clk);
    #1;
    n_tests++; if (got_q.size() - base !== 16) begin n_fail++; $display("FAIL loop_count: got %0d expected 16", got_q.size() - base); end
    for (int i = 0; i < 16; i++) begin
      if (base + i < got_q.size()) begin
        n_tests++; if (got_q[base+i] !== sent[i]) begin n_fail++; $display("FAIL loop_byte%0d: got %h expected %h", i, got_q[base+i], sent[i]); end
      end
    end
    n_tests++; if (data_out !== exp_data) begin n_fail++; $display("FAIL loop_last: got %h expected %h", data_out, exp_data); end
  endtask

  task automatic test_global_rules();
    n_tests++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL total_bytes: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL order%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_and_ferr: got %0d cycles expected 0", both_cnt); end
    n_tests++; if (long_cnt !== 0) begin n_fail++; $display("FAIL valid_width: got %0d extra cycles expected 0", long_cnt); end
    n_tests++; if (unstable_cnt !== 0) begin n_fail++; $display("FAIL data_stable: got %0d changes expected 0", unstable_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    test_global_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL expose parameters: CLK_FREQ, default 50_000_000, system clock in Hz; BAUD_RATE, default 2400, line bit rate; OVERSAMPLE, default 16, sample ticks per bit.
REQ-002 SHALL have port: clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port: srst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: rx  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port: data_out  output  8  last correctly received byte.
REQ-006 SHALL have port: valid  output  1  one-cycle pulse when data_out updates.
REQ-007 SHALL have port: busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port: frame_err  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; this adds 2 clk of latency.
REQ-010 SHALL generate a sample tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clk from a free-running counter that wraps at DIV-1; the counter width is $clog2(DIV).
REQ-011 SHALL use FSM states IDLE, START, DATA, STOP; all transitions occur only on a sample tick.
REQ-012 SHALL go IDLE->START on the first tick with synchronized rx=0, clearing the tick count to 0.
REQ-013 SHALL, in START, resample at tick count OVERSAMPLE/2-1: rx=0 -> DATA with tick count 0 and bit index 0; rx=1 (glitch) -> IDLE with no output pulse.
REQ-014 SHALL, in DATA, sample rx every OVERSAMPLE ticks, shifting LSB-first into a shift register; after bit index 7 it goes to STOP.
REQ-015 SHALL, in STOP, sample after OVERSAMPLE ticks: rx=1 -> load data_out from the shift register, pulse valid for exactly one clk, go IDLE.
REQ-016 SHALL, on a STOP sample of rx=0, pulse frame_err for one clk, leave data_out unchanged, and go IDLE only after rx is seen high (no false restart on a break).
REQ-017 SHALL drive busy high in START, DATA and STOP, and low in IDLE.
REQ-018 SHALL accept a new start bit on the tick after the STOP sample, so back-to-back frames with one stop bit are received without loss.
REQ-019 SHALL never assert valid and frame_err in the same cycle.
REQ-020 SHALL hold data_out stable between valid pulses; there is no consumer handshake and an unread byte is overwritten.

Reset
REQ-021 SHALL on srst asynchronously force: state IDLE, tick and bit counters 0, shift register 0, data_out 8'h00, valid 0, busy 0, frame_err 0, synchronizer flops 1.
REQ-022 SHALL abandon any frame in progress on reset mid-frame, with no valid or frame_err pulse after release, and resume start detection from IDLE.

Structure
REQ-023 SHALL take the state enum (IDLE, START, DATA, STOP) and the frame constants (DATA_BITS=8, IDLE_LEVEL=1) from the shared package uart_pkg, which uart_tx also uses.
REQ-024 SHALL instantiate one sub-module, uart_rx_sync (2-flop synchronizer); the tick divider and FSM are implemented inline.

Verification (CLK_FREQ=384000, BAUD_RATE=2400, OVERSAMPLE=16 -> DIV=10, bit = 160 clk)
REQ-025 SHALL cover: frame 0xA5 with a valid stop bit -> data_out=8'hA5, valid high for 1 clk, busy low afterwards, frame_err 0.
REQ-026 SHALL cover: rx low for 40 clk then high -> no valid, no frame_err, busy returns to 0 within 8 ticks.
REQ-027 SHALL cover: frame 0x3C with a low stop bit held for 320 clk -> frame_err pulse, no valid, data_out keeps its previous value, busy stays high until rx goes high.
REQ-028 SHALL cover: back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, with data_out 8'h00 then 8'hFF.
REQ-029 SHALL cover: srst asserted at bit 4 of 0x81 -> all outputs at reset values immediately, no pulse after release; the next frame 0x55 -> data_out=8'h55.
REQ-030 SHALL cover: a uart_tx to uart_rx loopback of 16 random bytes -> every byte matches in order.
